// File: rtl/s2p_frame_rx.sv
// Serial-to-parallel frame receiver: start 0, WIDTH data bits, optional even parity, stop 1.
// Define S2P_PARITY_EN at compile time to enable the parity bit and parityErr.
module s2p_frame_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             srClock,
  input  logic             rst,
  input  logic             bitEn,
  input  logic             dataIn,
  input  logic             dataReady,
  output logic [WIDTH-1:0] data,
  output logic             dataValid,
  output logic             busy,
  output logic             frameErr,
  output logic             overrun,
  output logic             parityErr
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

`ifdef S2P_PARITY_EN
  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StData, StStop} state_e;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  shift_q, shift_next;
  logic [WIDTH-1:0]  data_q;
  logic              valid_q, frame_err_q, overrun_q;
  logic              stop_edge;

  always_ff @(posedge srClock) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bitEn) begin
      unique case (state_q)
        StIdle: if (!dataIn) state_d = StData;
        StData: begin
          if (cnt_q == LastBit) begin
`ifdef S2P_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
`ifdef S2P_PARITY_EN
        StParity: state_d = StStop;
`endif
        StStop:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != StIdle);
  end

  // First received bit ends up in data[0] (LSB-first) or data[WIDTH-1] (MSB-first).
  always_comb begin
    if (MSB_FIRST != 0) shift_next = {shift_q[WIDTH-2:0], dataIn};
    else                shift_next = {dataIn, shift_q[WIDTH-1:1]};
  end

  assign stop_edge = bitEn && (state_q == StStop);

  always_ff @(posedge srClock) begin
    if (rst) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (bitEn && (state_q == StData)) begin
        shift_q <= shift_next;
        cnt_q   <= (cnt_q == LastBit) ? '0 : cnt_q + CntW'(1);
      end
      if (stop_edge && dataIn) begin
        if (!valid_q || dataReady) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (dataReady) begin
        valid_q <= 1'b0;
      end
      if (stop_edge && !dataIn) frame_err_q <= 1'b1;
    end
  end

`ifdef S2P_PARITY_EN
  logic parity_err_q;

  // Even parity: data ones plus parity bit must be even.
  always_ff @(posedge srClock) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else if (bitEn && (state_q == StParity) && ((^shift_q) ^ dataIn)) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parityErr = parity_err_q;
`else
  assign parityErr = 1'b0;
`endif

  assign data      = data_q;
  assign dataValid = valid_q;
  assign frameErr  = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/s2p_frame_rx.md
S2P_FRAME_RX -- requirements
Module: s2p_frame_rx

Interface
REQ-001 Parameter WIDTH, default 8, meaning data bits per frame (legal 2..32).
REQ-002 Parameter MSB_FIRST, default 0, meaning 0 = first data bit received lands in data[0], 1 = first data bit lands in data[WIDTH-1].
REQ-003 srClock  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 bitEn  input  1  bit strobe; dataIn sampled only on edges where bitEn=1.
REQ-006 dataIn  input  1  serial line; idle high.
REQ-007 dataReady  input  1  consumer acknowledge for the held word.
REQ-008 data  output  WIDTH  last accepted parallel word.
REQ-009 dataValid  output  1  data holds an unconsumed word.
REQ-010 busy  output  1  frame reception in progress (state not IDLE).
REQ-011 frameErr  output  1  sticky; stop bit sampled 0.
REQ-012 overrun  output  1  sticky; frame completed while previous word unconsumed.
REQ-013 parityErr  output  1  sticky; parity mismatch (tied 0 when parity disabled).

Function
REQ-014 Frame format SHALL be: start bit 0, WIDTH data bits, optional parity bit (REQ-030), stop bit 1; one bit per bitEn edge.
REQ-015 States SHALL be IDLE, DATA, PARITY, STOP; bitEn=0 holds state, bit counter and shift register unchanged.
REQ-016 IDLE -> DATA when bitEn=1 and dataIn=0; dataIn=1 stays IDLE.
REQ-017 DATA SHALL shift in one bit per strobe with a bit counter 0..WIDTH-1; after bit WIDTH-1 -> PARITY if enabled, else STOP.
REQ-018 PARITY SHALL sample one bit then -> STOP.
REQ-019 STOP SHALL sample the stop bit then -> IDLE on the same edge; next start bit accepted on the following strobe.
REQ-020 Stop bit 1: word is delivered per REQ-022; stop bit 0: word discarded, frameErr set, dataValid/data unchanged.
REQ-021 Latency: dataValid=1 and data updated on the edge that samples a valid stop bit (visible in the following cycle).
REQ-022 Delivery: if dataValid=0, or dataValid=1 with dataReady=1 that cycle, data loads and dataValid=1, overrun unchanged; if dataValid=1 and dataReady=0, data keeps old word, new word dropped, overrun set.
REQ-023 dataValid SHALL clear on an edge where dataReady=1 and no word is delivered; dataReady with dataValid=0 has no effect.
REQ-024 Sticky flags SHALL clear only on rst.
REQ-025 Shift register width SHALL be exactly WIDTH; no truncation or padding of data.

Reset
REQ-026 On rst=1 at a rising edge: state IDLE, bit counter 0, shift register 0, data=0, dataValid=0, busy=0, frameErr=0, overrun=0, parityErr=0.
REQ-027 rst mid-frame SHALL abort the frame; partial bits discarded, no delivery.
REQ-028 rst SHALL take priority over bitEn and dataReady in the same cycle.

Configuration
REQ-029 Macro S2P_PARITY_EN SHALL select the parity feature at compile time.
REQ-030 With S2P_PARITY_EN defined: PARITY state present; even parity (data ones + parity bit even); mismatch sets parityErr and word is still delivered if stop bit valid.
REQ-031 Without S2P_PARITY_EN: PARITY state absent, DATA -> STOP directly, parityErr constant 0, frame is WIDTH+2 bits.

Verification
REQ-032 WIDTH=8, MSB_FIRST=0, no parity, bitEn=1: send 0, bits 1,0,1,0,1,1,0,1, stop 1 -> data=0xB5, dataValid=1 nine edges after the start edge, all flags 0.
REQ-033 Same bit stream with MSB_FIRST=1 -> data=0xAD.
REQ-034 Two frames 0xB5 then 0x3C with dataReady=0 -> data stays 0xB5, overrun=1; repeat with dataReady=1 on second stop edge -> data=0x3C, overrun=0.
REQ-035 Frame 0x55 with stop bit 0 -> frameErr=1, dataValid=0, data=0x00; rst mid-DATA after 4 bits -> busy=0 next cycle, no dataValid.
REQ-036 S2P_PARITY_EN, 0xB5 with parity bit 1 -> parityErr=0, data=0xB5; parity bit 0 -> parityErr=1, data=0xB5.
REQ-037 bitEn toggling 1,0,0,1 per bit for frame 0x81 -> data=0x81, state holds during bitEn=0 cycles.
